// File: rtl/mc_control_unit.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXECUTE/MEM/WB with
// illegal-opcode and data-bus-timeout traps.
module mc_control_unit #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       btaken,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       ir_en,
    output logic       regfile_we,
    output logic       alu_src,
    output logic       wdata_sel,
    output logic       branch_sel,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       illegal,
    output logic       timeout_err,
    output logic [3:0] alu_control,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LD, C_ST, C_BR, C_ILL
    } cls_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    state_t     state;
    cls_t       cls;
    cls_t       dec_cls;
    logic [3:0] dec_alu;
    logic       dec_src;
    logic [3:0] alu_q;
    logic       src_q;
    logic [7:0] cnt;
    logic       ill_q;
    logic       to_q;

    always_comb begin
        dec_cls = C_ILL;
        case (opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LD;
            7'b0100011: dec_cls = C_ST;
            7'b1100011: dec_cls = C_BR;
            default:    dec_cls = C_ILL;
        endcase
    end

    always_comb begin
        dec_alu = 4'b0000;
        dec_src = 1'b0;
        case (dec_cls)
            C_R:  dec_alu = {funct7_5, funct3};
            C_I: begin
                // funct7_5 only distinguishes SRLI/SRAI among immediates
                dec_alu = {(funct3 == 3'b101) & funct7_5, funct3};
                dec_src = 1'b1;
            end
            C_LD, C_ST: dec_src = 1'b1;
            C_BR: dec_alu = 4'b1000;
            default: begin
                dec_alu = 4'b0000;
                dec_src = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            cls   <= C_R;
            alu_q <= 4'b0000;
            src_q <= 1'b0;
            cnt   <= 8'd0;
            ill_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    cls   <= dec_cls;
                    alu_q <= dec_alu;
                    src_q <= dec_src;
                    if (dec_cls == C_ILL) begin
                        state <= TRAP;
                        ill_q <= 1'b1;
                    end else begin
                        state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    cnt <= 8'd0;
                    case (cls)
                        C_R, C_I:   state <= WB;
                        C_LD, C_ST: state <= MEM;
                        default:    state <= FETCH;
                    endcase
                end
                MEM: begin
                    // ready in the final allowed cycle still completes
                    if (dmem_ready) begin
                        state <= (cls == C_LD) ? WB : FETCH;
                    end else if (cnt + 8'd1 >= TO_LIM) begin
                        state <= TRAP;
                        to_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WB:      state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    logic in_mem;
    logic is_br;
    assign in_mem = reset && (state == MEM);
    assign is_br  = reset && (state == EXECUTE) && (cls == C_BR);

    assign ir_en      = reset && (state == FETCH);
    assign regfile_we = reset && (state == WB);
    assign wdata_sel  = regfile_we && (cls == C_LD);
    assign dmem_req   = in_mem;
    assign dmem_we    = in_mem && (cls == C_ST);
    assign branch_sel = is_br && btaken;
    assign pc_en      = is_br || regfile_we || (dmem_we && dmem_ready);
    assign illegal    = ill_q;
    assign timeout_err = to_q;
    assign state_o    = state;

    // DECODE shows the fresh decode so the value is stable from DECODE on
    assign alu_control = !reset ? 4'b0000 :
                         (state == DECODE) ? dec_alu : alu_q;
    assign alu_src     = reset && ((state == DECODE) ? dec_src : src_q);

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed table-driven bench for mc_control_unit plus hand-written
// reset, trap-hold and mid-MEM reset sequences.
module tb_mc_control_unit;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       btaken;
    logic       dmem_ready;
    logic       pc_en, ir_en, regfile_we, alu_src, wdata_sel;
    logic       branch_sel, dmem_req, dmem_we, illegal, timeout_err;
    logic [3:0] alu_control;
    logic [2:0] state_o;

    int errs = 0;
    int checks = 0;

    mc_control_unit #(.TIMEOUT_CYC(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .btaken(btaken), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ir_en(ir_en), .regfile_we(regfile_we),
        .alu_src(alu_src), .wdata_sel(wdata_sel),
        .branch_sel(branch_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .illegal(illegal), .timeout_err(timeout_err),
        .alu_control(alu_control), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       bt;
        logic       noise;
        int         w;
        int         lat;
        int         alu;
        int         src;
        int         req;
        int         we;
        int         rf;
        int         wsel;
        int         pc;
        int         bsel;
        int         fin;
        int         ill;
        int         to;
    } vec_t;

    vec_t v[15];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_outs", {pc_en, ir_en, regfile_we, alu_src, wdata_sel,
                         branch_sel, dmem_req, dmem_we, illegal,
                         timeout_err}, 0);
        chk("rst_alu", alu_control, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rel_ir_en", ir_en, 1);
        chk("rel_state", state_o, 0);
    endtask

    task automatic run_vec(input int k);
        int cyc = 0, mem = 0, req = 0, we = 0, rf = 0, wsel = 0;
        int pc = 0, bsel = 0, unstable = 0, overlap = 0;
        logic [3:0] alu_cap = 4'b0;
        logic src_cap = 1'b0;
        if (state_o == 3'd7) do_reset();
        opcode = v[k].op;
        funct3 = v[k].f3;
        funct7_5 = v[k].f7;
        btaken = v[k].bt;
        forever begin
            @(negedge clk);
            dmem_ready = (state_o == 3'd3) ? (mem == v[k].w) : v[k].noise;
            #1;
            if (state_o == 3'd3) mem++;
            if (dmem_req) req++;
            if (dmem_we) we++;
            if (regfile_we) rf++;
            if (regfile_we && wdata_sel) wsel++;
            if (pc_en) pc++;
            if (pc_en && branch_sel) bsel++;
            if (ir_en && (pc_en || regfile_we)) overlap++;
            if (pc_en && regfile_we && state_o != 3'd4) overlap++;
            if (state_o == 3'd1) begin
                alu_cap = alu_control;
                src_cap = alu_src;
            end
            if (state_o >= 3'd2 && state_o <= 3'd4 &&
                (alu_control != alu_cap || alu_src != src_cap))
                unstable++;
            cyc++;
            @(posedge clk);
            #1;
            if (state_o == 3'd0 || state_o == 3'd7 || cyc >= 40) break;
        end
        dmem_ready = 1'b0;
        chk($sformatf("v%0d_latency", k), cyc, v[k].lat);
        chk($sformatf("v%0d_alu", k), alu_cap, v[k].alu);
        chk($sformatf("v%0d_alu_src", k), src_cap, v[k].src);
        chk($sformatf("v%0d_dmem_req", k), req, v[k].req);
        chk($sformatf("v%0d_dmem_we", k), we, v[k].we);
        chk($sformatf("v%0d_regfile_we", k), rf, v[k].rf);
        chk($sformatf("v%0d_wdata_sel", k), wsel, v[k].wsel);
        chk($sformatf("v%0d_pc_en", k), pc, v[k].pc);
        chk($sformatf("v%0d_branch_sel", k), bsel, v[k].bsel);
        chk($sformatf("v%0d_end_state", k), state_o, v[k].fin);
        chk($sformatf("v%0d_illegal", k), illegal, v[k].ill);
        chk($sformatf("v%0d_timeout", k), timeout_err, v[k].to);
        chk($sformatf("v%0d_stable", k), unstable, 0);
        chk($sformatf("v%0d_overlap", k), overlap, 0);
        if (v[k].fin == 7) begin
            // trap must absorb, even with ready toggling
            dmem_ready = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_trap_hold", k), state_o, 7);
            chk($sformatf("v%0d_trap_outs", k),
                {pc_en, ir_en, regfile_we, dmem_req, dmem_we}, 0);
            chk($sformatf("v%0d_sticky", k),
                {illegal, timeout_err}, {v[k].ill[0], v[k].to[0]});
            dmem_ready = 1'b0;
        end
    endtask

    initial begin
        //        op          f3    f7 bt nz w   lat alu     src req we rf ws pc bs fin il to
        v[0]  = '{7'b0110011, 3'b000, 0, 0, 0, 0,   4, 4'b0000, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
        v[1]  = '{7'b0110011, 3'b000, 1, 0, 1, 0,   4, 4'b1000, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
        v[2]  = '{7'b0010011, 3'b101, 1, 0, 0, 0,   4, 4'b1101, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0};
        v[3]  = '{7'b0010011, 3'b000, 1, 0, 0, 0,   4, 4'b0000, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0};
        v[4]  = '{7'b0010011, 3'b101, 0, 0, 0, 0,   4, 4'b0101, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0};
        v[5]  = '{7'b0000011, 3'b010, 0, 0, 0, 3,   8, 4'b0000, 1, 4, 0, 1, 1, 1, 0, 0, 0, 0};
        v[6]  = '{7'b0000011, 3'b010, 1, 0, 1, 0,   5, 4'b0000, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0};
        v[7]  = '{7'b0100011, 3'b010, 0, 0, 0, 2,   6, 4'b0000, 1, 3, 3, 0, 0, 1, 0, 0, 0, 0};
        v[8]  = '{7'b0100011, 3'b010, 0, 0, 0, 14, 18, 4'b0000, 1, 15, 15, 0, 0, 1, 0, 0, 0, 0};
        v[9]  = '{7'b1100011, 3'b000, 0, 1, 0, 0,   3, 4'b1000, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        v[10] = '{7'b1100011, 3'b000, 0, 0, 1, 0,   3, 4'b1000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        v[11] = '{7'b0100011, 3'b010, 0, 0, 0, 999, 18, 4'b0000, 1, 15, 15, 0, 0, 0, 0, 7, 0, 1};
        v[12] = '{7'b1111111, 3'b000, 0, 0, 0, 0,   2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0};
        v[13] = '{7'b0000011, 3'b010, 0, 0, 0, 999, 18, 4'b0000, 1, 15, 0, 0, 0, 0, 0, 7, 0, 1};
        v[14] = '{7'b0110111, 3'b000, 0, 0, 1, 0,   2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0};

        reset = 1'b0;
        opcode = 7'b0;
        funct3 = 3'b0;
        funct7_5 = 1'b0;
        btaken = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        for (int k = 0; k < 15; k++) run_vec(k);

        // illegal clears on reset pulse
        if (state_o == 3'd7) do_reset();
        chk("post_reset_illegal", {illegal, timeout_err}, 0);

        // reset asserted in the middle of a MEM wait
        opcode = 7'b0100011;
        funct3 = 3'b010;
        dmem_ready = 1'b0;
        for (int i = 0; i < 10 && state_o != 3'd3; i++) @(negedge clk);
        @(negedge clk);
        chk("midmem_req_before", {dmem_req, dmem_we}, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("midmem_req_drop", {dmem_req, dmem_we}, 0);
        chk("midmem_enables", {pc_en, ir_en, regfile_we}, 0);
        chk("midmem_state", state_o, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midmem_rel_ir_en", ir_en, 1);
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15, giving the maximum MEM-state wait cycles (1..255) before a bus-timeout trap.
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port opcode  input  7  instruction bits [6:0] from the instruction register.
REQ-005 SHALL have port funct3  input  3  instruction bits [14:12].
REQ-006 SHALL have port funct7_5  input  1  instruction bit 30.
REQ-007 SHALL have port btaken  input  1  branch-comparator result for the current B-type instruction.
REQ-008 SHALL have port dmem_ready  input  1  data-memory completion strobe.
REQ-009 SHALL have outputs pc_en, ir_en, regfile_we, alu_src, wdata_sel, branch_sel, dmem_req, dmem_we, illegal, timeout_err, each 1 bit.
- alu_src: 1 = immediate.
- wdata_sel: 1 = memory data.
- branch_sel: 1 = PC+imm, else PC+4.
REQ-010 SHALL have outputs alu_control  output  4  ALU operation, and state_o  output  3  current state code.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=7, and SHALL drive the current code on state_o.
REQ-012 SHALL classify opcodes as follows; every other opcode is illegal.
- 0110011 R
- 0010011 I-ALU
- 0000011 LOAD
- 0100011 STORE
- 1100011 BRANCH
REQ-013 FETCH SHALL assert ir_en for one cycle, then go to DECODE.
REQ-014 DECODE SHALL go to EXECUTE for a legal opcode; otherwise it SHALL go to TRAP and set illegal.
REQ-015 EXECUTE SHALL branch on instruction class.
- R / I-ALU: go to WB.
- LOAD / STORE: go to MEM.
- BRANCH: assert pc_en, drive branch_sel=btaken, go to FETCH.
REQ-016 MEM SHALL hold dmem_req=1, with dmem_we=1 for STORE only, until dmem_ready is sampled high.
- On that edge, LOAD SHALL go to WB.
- STORE SHALL go to FETCH, with pc_en asserted combinationally in the dmem_ready cycle.
REQ-017 WB SHALL assert regfile_we and pc_en for one cycle, with wdata_sel=1 for LOAD and 0 otherwise, then go to FETCH.
REQ-018 TRAP SHALL be absorbing until reset, with all enables, dmem_req and dmem_we at 0.
REQ-019 alu_src SHALL be 1 for I-ALU, LOAD and STORE, and 0 for R and BRANCH.
REQ-020 alu_control SHALL be encoded as follows.
- R: {funct7_5, funct3}.
- I-ALU: {funct3==3'b101 ? funct7_5 : 0, funct3}.
- LOAD/STORE: 4'b0000 (ADD).
- BRANCH: 4'b1000 (SUB).
REQ-021 alu_control and alu_src SHALL be held stable from DECODE through WB.
REQ-022 A wait counter SHALL clear on MEM entry and increment each MEM cycle without dmem_ready.
- If it reaches TIMEOUT_CYC with dmem_ready still low, the FSM SHALL go to TRAP and set timeout_err.
- dmem_ready arriving in the cycle the count equals TIMEOUT_CYC SHALL complete normally; ready wins.
REQ-023 illegal and timeout_err SHALL be sticky until reset and mutually exclusive.
REQ-024 The block SHALL ignore dmem_ready in every state except MEM.
REQ-025 Instruction latencies, in cycles from FETCH entry to the next FETCH entry, SHALL be:
- R / I-ALU: 4.
- BRANCH: 3.
- STORE: 4+w.
- LOAD: 5+w.
- w = MEM wait cycles.
REQ-026 At most one of pc_en, ir_en and regfile_we SHALL be high in any cycle, except that regfile_we and pc_en SHALL both be high in WB.

Reset
REQ-027 While reset=0, the FSM SHALL be FETCH and the wait counter 0.
REQ-028 While reset=0, every 1-bit output SHALL be 0, alu_control SHALL be 4'b0000 and state_o SHALL be 3'd0.
REQ-029 Reset assertion mid-instruction, including mid-MEM wait, SHALL immediately drop dmem_req and dmem_we, with no write-enable glitch.
REQ-030 After reset release, ir_en SHALL assert on the first rising clk edge.

Verification
REQ-031 ADD x3,x1,x2: opcode=0110011, funct3=000, funct7_5=0 -> state_o 0,1,2,4,0; alu_control=0000, alu_src=0, regfile_we=1 only in WB; 4 cycles.
REQ-032 SRAI: opcode=0010011, funct3=101, funct7_5=1 -> alu_control=1101, alu_src=1, regfile_we in cycle 4.
REQ-033 LW with dmem_ready high after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, wdata_sel=1 in WB; 8 cycles total.
REQ-034 SW with dmem_ready never high, TIMEOUT_CYC=15 -> dmem_we=1 for 15 MEM cycles, then state_o=7, timeout_err=1, all enables 0.
REQ-035 BEQ with btaken=1, then BEQ with btaken=0 -> pc_en=1 in EXECUTE with branch_sel=1 and 0 respectively; 3 cycles each.
REQ-036 opcode=1111111 -> TRAP after DECODE, illegal=1; reset pulse low -> FETCH, illegal=0.
